// File: rtl/cfg_cbit_loader.sv
// cfg_cbit_loader: serial loader for routing-mux config bits.
// Shifts NWORDS words of CW bits in LSB-first and drives each word as a
// complementary cbit/cbitb pair, sequencing the fabric prog strobe.
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   start, abort        begin a frame (IDLE only) / cancel a load
//   sdi, sdi_vld        serial data and its valid
//   sdi_rdy             loader accepts sdi this cycle (SHIFT only)
//   prog                fabric programming strobe
//   cbit, cbitb         config words and their complement
//   busy, done, err     not-IDLE, frame-loaded pulse, frame-aborted pulse
module cfg_cbit_loader #(
    parameter int CW         = 6,
    parameter int NWORDS     = 4,
    parameter int SETTLE_CYC = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 sdi,
    input  logic                 sdi_vld,
    output logic                 sdi_rdy,
    output logic                 prog,
    output logic [NWORDS*CW-1:0] cbit,
    output logic [NWORDS*CW-1:0] cbitb,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int BW = (CW > 1) ? $clog2(CW) : 1;
    localparam int WW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PROG_ON = 3'd1;
    localparam logic [2:0] S_SHIFT   = 3'd2;
    localparam logic [2:0] S_COMMIT  = 3'd3;
    localparam logic [2:0] S_SETTLE  = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    logic [2:0]           r_state;
    logic [BW-1:0]        r_bitcnt;
    logic [WW-1:0]        r_widx;
    logic [SW-1:0]        r_scnt;
    logic [CW-1:0]        r_sh;
    logic [NWORDS*CW-1:0] r_cbit;
    logic [NWORDS*CW-1:0] r_cbitb;
    logic                 r_sdi_rdy;
    logic                 r_prog;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    logic       w_abort;
    logic       w_last_bit;
    logic       w_last_word;
    logic       w_last_settle;
    logic [2:0] w_nstate;

    always_comb begin
        w_last_bit    = (r_bitcnt == BW'(CW - 1));
        w_last_word   = (r_widx == WW'(NWORDS - 1));
        w_last_settle = (r_scnt == SW'(SETTLE_CYC - 1));
        // abort only matters while a load is actually in flight
        w_abort = abort && (r_state == S_PROG_ON || r_state == S_SHIFT ||
                            r_state == S_COMMIT || r_state == S_SETTLE);
        w_nstate = r_state;
        if (w_abort) begin
            w_nstate = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:    if (start) w_nstate = S_PROG_ON;
                S_PROG_ON: w_nstate = S_SHIFT;
                S_SHIFT:   if (sdi_vld && w_last_bit) w_nstate = S_COMMIT;
                S_COMMIT:  w_nstate = w_last_word ? S_SETTLE : S_SHIFT;
                S_SETTLE:  if (w_last_settle) w_nstate = S_RELEASE;
                S_RELEASE: w_nstate = S_IDLE;
                default:   w_nstate = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bitcnt  <= '0;
            r_widx    <= '0;
            r_scnt    <= '0;
            r_sh      <= '0;
            r_cbit    <= '0;
            r_cbitb   <= '1;
            r_sdi_rdy <= 1'b0;
            r_prog    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_nstate;
            // registered outputs track the state being entered
            r_sdi_rdy <= (w_nstate == S_SHIFT);
            r_busy    <= (w_nstate != S_IDLE);
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            if (w_abort) begin
                r_cbit  <= '0;
                r_cbitb <= '1;
                r_prog  <= 1'b1;
                r_err   <= 1'b1;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_prog   <= 1'b1;
                            r_bitcnt <= '0;
                            r_widx   <= '0;
                            r_scnt   <= '0;
                        end
                    end
                    S_SHIFT: begin
                        if (sdi_vld) begin
                            r_sh     <= {sdi, r_sh[CW-1:1]};
                            r_bitcnt <= w_last_bit ? '0 : r_bitcnt + 1'b1;
                        end
                    end
                    S_COMMIT: begin
                        // both slices from the same source on the same edge
                        r_cbit[r_widx*CW +: CW]  <= r_sh;
                        r_cbitb[r_widx*CW +: CW] <= ~r_sh;
                        if (!w_last_word) r_widx <= r_widx + 1'b1;
                        r_scnt <= '0;
                    end
                    S_SETTLE: begin
                        if (w_last_settle) begin
                            r_prog <= 1'b0;
                            r_done <= 1'b1;
                        end else begin
                            r_scnt <= r_scnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sdi_rdy = r_sdi_rdy;
    assign prog    = r_prog;
    assign cbit    = r_cbit;
    assign cbitb   = r_cbitb;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule
